// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word slave: edge-role encoding and the
// CPOL/CPHA to sample/shift edge mapping.
package spi_pkg;

   typedef enum logic {
      EDGE_RISE,
      EDGE_FALL
   } edge_t;

   function automatic edge_t sample_edge(input bit cpol, input bit cpha);
      edge_t lead;
      lead = cpol ? EDGE_FALL : EDGE_RISE;
      if (cpha)
         return (lead == EDGE_RISE) ? EDGE_FALL : EDGE_RISE;
      return lead;
   endfunction

   function automatic edge_t shift_edge(input bit cpol, input bit cpha);
      return (sample_edge(cpol, cpha) == EDGE_RISE) ? EDGE_FALL : EDGE_RISE;
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one asynchronous SPI input, with edge pulses
// taken against one further registered copy of the synced level.
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Deliberately not reset: a reset in mid-frame must not fabricate a CS edge.
   always_ff @(posedge clk) begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
   end

   assign level = chain[SYNC_STAGES-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave in the system clock domain: all CPOL/CPHA modes, back-to-back
// words per frame, valid/ready RX port and one-deep TX holding register.
module spi_word_slave
   import spi_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int MSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_clk,
   input  logic             spi_cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             frame_start,
   output logic             frame_end,
   output logic             rx_overrun,
   output logic             tx_underrun
);

   localparam edge_t SAMPLE_EDGE = sample_edge(CPOL != 0, CPHA != 0);
   localparam edge_t SHIFT_EDGE  = shift_edge(CPOL != 0, CPHA != 0);
   localparam int    CW          = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .din(spi_clk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .din(spi_cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .din(mosi), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

   assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

   logic [CW-1:0]    bit_cnt;
   logic             load_pending;
   logic             selected;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] shift_out;
   logic [WIDTH-1:0] rx_shift;

   logic             active, sample_ev, shift_ev, do_load, out_bit;
   logic [WIDTH-1:0] rx_next, tx_adv;

   always_comb begin
      active    = selected & ~cs_lvl;
      sample_ev = (SAMPLE_EDGE == EDGE_RISE) ? sclk_rise : sclk_fall;
      shift_ev  = (SHIFT_EDGE == EDGE_RISE) ? sclk_rise : sclk_fall;
      do_load   = 1'b0;
      if (cs_fall)
         do_load = (CPHA == 0);
      else if (active && shift_ev && load_pending)
         do_load = 1'b1;
      if (MSB_FIRST != 0) begin
         rx_next = {rx_shift[WIDTH-2:0], mosi_lvl};
         tx_adv  = {shift_out[WIDTH-2:0], 1'b0};
         out_bit = shift_out[WIDTH-1];
      end else begin
         rx_next = {mosi_lvl, rx_shift[WIDTH-1:1]};
         tx_adv  = {1'b0, shift_out[WIDTH-1:1]};
         out_bit = shift_out[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt      <= '0;
         load_pending <= 1'b0;
         selected     <= 1'b0;
         hold         <= '0;
         shift_out    <= '0;
         rx_shift     <= '0;
         tx_ready     <= 1'b1;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_start  <= 1'b0;
         frame_end    <= 1'b0;
         rx_overrun   <= 1'b0;
         tx_underrun  <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         if (tx_valid && tx_ready) begin
            hold     <= tx_data;
            tx_ready <= 1'b0;
         end

         if (cs_fall) begin
            frame_start  <= 1'b1;
            selected     <= 1'b1;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            load_pending <= (CPHA != 0);
         end else if (cs_rise && selected) begin
            frame_end    <= 1'b1;
            selected     <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            shift_out    <= '0;
            load_pending <= 1'b0;
         end else if (active) begin
            if (shift_ev && load_pending)
               load_pending <= 1'b0;
            else if (shift_ev)
               shift_out <= tx_adv;
            if (sample_ev) begin
               rx_shift <= rx_next;
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt      <= '0;
                  rx_data      <= rx_next;
                  rx_valid     <= 1'b1;
                  load_pending <= 1'b1;
                  if (rx_valid && !rx_ready)
                     rx_overrun <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         end

         // Load overrides the shift and the holding-register write above;
         // an empty holding register with tx_valid present bypasses tx_data.
         if (do_load) begin
            if (!tx_ready) begin
               shift_out <= hold;
               tx_ready  <= 1'b1;
            end else if (tx_valid) begin
               shift_out <= tx_data;
               tx_ready  <= 1'b1;
            end else begin
               shift_out   <= '0;
               tx_underrun <= 1'b1;
            end
         end
      end
   end

   assign miso    = selected & out_bit;
   assign miso_oe = selected;

endmodule
